// File: rtl/evt_pkg.sv
// Types and helpers shared by the event burst generator and the event counter it feeds.
// The index wrap lives here so that both ends of the link agree after every strobe.
package evt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } evt_gen_state_t;

    localparam int CNT_W_DEFAULT = 16;

    // Modulo-max increment. The arguments are 32 bits wide so that a modulus of 65536 can be passed.
    function automatic logic [31:0] next_idx(input logic [31:0] cur, input logic [31:0] max);
        logic [31:0] nxt;
        if (cur == max - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/evt_burst_gen_if.sv
// Control and strobe bundle between a burst requester (master) and the generator (slave).
interface evt_burst_gen_if
    import evt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             start_in;
    logic             stop_in;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] burst_in;
    logic             evt_out;
    logic [CNT_W-1:0] idx_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in,
        output stop_in,
        output period_in,
        output burst_in,
        input  evt_out,
        input  idx_out,
        input  busy_out,
        input  done_out
    );

    modport slave (
        input  start_in,
        input  stop_in,
        input  period_in,
        input  burst_in,
        output evt_out,
        output idx_out,
        output busy_out,
        output done_out
    );

endinterface

// File: rtl/evt_burst_gen_period_timer.sv
// Reloading down-counter that paces the strobes. It is loaded with P-1 and ticks each
// time it reaches zero while enabled, which gives exactly one tick every P enabled cycles.
module evt_period_timer
    import evt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] reload_r;
    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == ZERO);

    // Hold the reload value and run the down-count.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            reload_r <= ZERO;
            cnt_r    <= ZERO;
        end else if (load) begin
            reload_r <= load_val;
            cnt_r    <= load_val;
        end else if (en) begin
            if (cnt_r == ZERO) begin
                cnt_r <= reload_r;
            end else begin
                cnt_r <= cnt_r - ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/evt_burst_gen.sv
// Paced event strobe generator: emits a burst of N strobes or a continuous stream, and carries
// a wrapping index that stays in step with a downstream event counter fed by evt_out.
module evt_burst_gen
    import evt_pkg::*;
#(
    parameter int MAX_COUNT = 40_000,  // legal range 2..65536
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input logic             clk_in,
    input logic             rst_in,
    evt_burst_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    evt_gen_state_t   state_r;
    logic [CNT_W-1:0] burst_r;
    logic [CNT_W-1:0] sent_r;
    logic             evt_r;
    logic [CNT_W-1:0] idx_r;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] load_val_s;
    logic             load_s;
    logic             tick_s;
    logic             timer_en_s;
    logic             last_s;
    logic [CNT_W-1:0] idx_nxt_s;

    // A period of 0 behaves like 1, so the timer reload value saturates at zero.
    always_comb begin
        load_val_s = ZERO;
        if (bus.period_in == ZERO) begin
            load_val_s = ZERO;
        end else begin
            load_val_s = bus.period_in - ONE;
        end
    end

    assign load_s     = (state_r == IDLE) && bus.start_in;
    assign timer_en_s = (state_r == RUN);
    assign last_s     = (burst_r != ZERO) && (sent_r == burst_r - ONE);
    assign idx_nxt_s  = CNT_W'(next_idx(32'(idx_r), 32'(MAX_COUNT)));

    evt_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load     (load_s),
        .load_val (load_val_s),
        .en       (timer_en_s),
        .tick     (tick_s)
    );

    // Control FSM with the burst counter, index and all registered outputs.
    // The index is deliberately not cleared by start, matching a free-running receiver.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            burst_r <= ZERO;
            sent_r  <= ZERO;
            evt_r   <= 1'b0;
            idx_r   <= ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            evt_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start_in) begin
                        burst_r <= bus.burst_in;
                        sent_r  <= ZERO;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    // Stop outranks a strobe that would land on the same edge.
                    if (bus.stop_in) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (tick_s) begin
                        evt_r <= 1'b1;
                        idx_r <= idx_nxt_s;
                        if (last_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            sent_r <= sent_r + ONE;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.evt_out  = evt_r;
    assign bus.idx_out  = idx_r;
    assign bus.busy_out = busy_r;
    assign bus.done_out = done_r;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Bench for evt_burst_gen: two instances (default modulus and modulus 5) share one stimulus;
// an abstract schedule model is compared every cycle, plus literal timing/index expectations.
module tb_evt_burst_gen;
    import evt_pkg::*;

    localparam int CW = 16;
    localparam int MA = 40000;
    localparam int MB = 5;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_s = 1'b0;
    logic          stop_s = 1'b0;
    logic [CW-1:0] period_s = '0;
    logic [CW-1:0] burst_s = '0;

    evt_burst_gen_if #(.CNT_W(CW)) bus_a ();
    evt_burst_gen_if #(.CNT_W(CW)) bus_b ();

    assign bus_a.start_in  = start_s;
    assign bus_a.stop_in   = stop_s;
    assign bus_a.period_in = period_s;
    assign bus_a.burst_in  = burst_s;
    assign bus_b.start_in  = start_s;
    assign bus_b.stop_in   = stop_s;
    assign bus_b.period_in = period_s;
    assign bus_b.burst_in  = burst_s;

    evt_burst_gen #(.MAX_COUNT(MA), .CNT_W(CW)) dut_a (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_a.slave)
    );

    evt_burst_gen #(.MAX_COUNT(MB), .CNT_W(CW)) dut_b (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_b.slave)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Schedule model: after start at edge N with P=max(period,1), strobes fall on edges N+k*P.
    int cyc = 0;
    bit m_run = 1'b0;
    int m_n = 0;
    int m_p = 1;
    int m_b = 0;
    int m_k = 0;
    int m_idx_a = 0;
    int m_idx_b = 0;
    bit e_evt = 1'b0;
    bit e_done = 1'b0;
    bit e_busy = 1'b0;

    initial begin
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) begin
                m_run = 1'b0; m_k = 0; m_idx_a = 0; m_idx_b = 0;
                e_evt = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            end else begin
                cyc = cyc + 1;
                e_evt = 1'b0;
                e_done = 1'b0;
                if (!m_run) begin
                    if (start_s) begin
                        m_run = 1'b1;
                        m_p = (int'(period_s) == 0) ? 1 : int'(period_s);
                        m_b = int'(burst_s);
                        m_k = 0;
                        m_n = cyc;
                        e_busy = 1'b1;
                    end
                end else if (stop_s) begin
                    m_run = 1'b0;
                    e_done = 1'b1;
                    e_busy = 1'b0;
                end else if (((cyc - m_n) % m_p) == 0) begin
                    e_evt = 1'b1;
                    m_k = m_k + 1;
                    m_idx_a = (m_idx_a + 1) % MA;
                    m_idx_b = (m_idx_b + 1) % MB;
                    if (m_b != 0 && m_k == m_b) begin
                        m_run = 1'b0;
                        e_done = 1'b1;
                        e_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus a receiver-side counter on evt_b.
    int ctr_b = 0;
    int evt_q[$];
    int done_q[$];
    int idxb_q[$];

    initial begin
        #2;
        forever begin
            @(negedge clk_in);
            chk("evt_a", int'(bus_a.evt_out), int'(e_evt));
            chk("done_a", int'(bus_a.done_out), int'(e_done));
            chk("busy_a", int'(bus_a.busy_out), int'(e_busy));
            chk("idx_a", int'(bus_a.idx_out), m_idx_a);
            chk("evt_b", int'(bus_b.evt_out), int'(e_evt));
            chk("idx_b", int'(bus_b.idx_out), m_idx_b);
            if (rst_in) begin
                ctr_b = 0;
            end else if (bus_b.evt_out) begin
                ctr_b = (ctr_b + 1) % MB;
                chk("ctr_b", int'(bus_b.idx_out), ctr_b);
            end
            if (bus_a.evt_out) begin
                evt_q.push_back(cyc);
                idxb_q.push_back(int'(bus_b.idx_out));
            end
            if (bus_a.done_out) done_q.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Pulse start for one edge; returns the edge number N at which start was taken.
    task automatic start_run(input int p, input int b, input bit with_stop, output int n0);
        @(negedge clk_in);
        evt_q.delete();
        done_q.delete();
        idxb_q.delete();
        period_s = CW'(p);
        burst_s  = CW'(b);
        start_s  = 1'b1;
        stop_s   = with_stop;
        @(negedge clk_in);
        start_s = 1'b0;
        stop_s  = 1'b0;
        n0 = cyc;
    endtask

    task automatic check_strobes(input string name, input int n0, input int p, input int cnt,
                                 input int done_off);
        chk({name, "_count"}, evt_q.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < evt_q.size()) chk({name, "_offset"}, evt_q[i] - n0, p * (i + 1));
        end
        chk({name, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({name, "_done_off"}, done_q[0] - n0, done_off);
    endtask

    int n0;

    initial begin
        #1 rst_in = 1'b1;
        idle(2);
        rst_in = 1'b0;
        chk("rst_idx", int'(bus_a.idx_out), 0);
        chk("rst_busy", int'(bus_a.busy_out), 0);

        // period 4, burst 3
        start_run(4, 3, 1'b0, n0);
        idle(16);
        check_strobes("t1", n0, 4, 3, 12);
        chk("t1_idx_a", int'(bus_a.idx_out), 3);
        chk("t1_idx_b", int'(bus_b.idx_out), 3);
        chk("t1_busy", int'(bus_a.busy_out), 0);

        // period 1, burst 4: modulus-5 index wraps 4,0,1,2
        start_run(1, 4, 1'b0, n0);
        idle(6);
        check_strobes("t3", n0, 1, 4, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < idxb_q.size()) chk("t3_idxb_seq", idxb_q[i], (i == 0) ? 4 : i - 1);
        end
        chk("t3_idx_a", int'(bus_a.idx_out), 7);

        // continuous, period 10, stop on the edge of the third strobe
        start_run(10, 0, 1'b0, n0);
        repeat (29) @(negedge clk_in);
        stop_s = 1'b1;
        @(negedge clk_in);
        stop_s = 1'b0;
        idle(5);
        check_strobes("t4", n0, 10, 2, 30);
        chk("t4_idx_a", int'(bus_a.idx_out), 9);
        chk("t4_idx_b", int'(bus_b.idx_out), 4);

        // asynchronous reset mid-burst
        start_run(3, 10, 1'b0, n0);
        idle(4);
        #2 rst_in = 1'b1;
        #1;
        chk("t5_idx_a", int'(bus_a.idx_out), 0);
        chk("t5_busy", int'(bus_a.busy_out), 0);
        chk("t5_evt", int'(bus_a.evt_out), 0);
        chk("t5_done", int'(bus_a.done_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(3);
        chk("t5_nodone", done_q.size(), 0);

        // period 0 behaves as 1: five back-to-back strobes from idx 0
        start_run(0, 5, 1'b0, n0);
        idle(7);
        check_strobes("t2", n0, 1, 5, 5);
        chk("t2_idx_a", int'(bus_a.idx_out), 5);
        chk("t2_idx_b", int'(bus_b.idx_out), 0);

        // start and new period/burst during RUN are ignored
        start_run(3, 2, 1'b0, n0);
        start_s = 1'b1;
        period_s = CW'(7);
        burst_s = CW'(9);
        @(negedge clk_in);
        start_s = 1'b0;
        idle(10);
        check_strobes("t6", n0, 3, 2, 6);
        chk("t6_idx_a", int'(bus_a.idx_out), 7);

        // stop in IDLE ignored
        done_q.delete();
        stop_s = 1'b1;
        @(negedge clk_in);
        stop_s = 1'b0;
        idle(2);
        chk("t7_idle_stop", done_q.size(), 0);

        // start with stop together in IDLE: start wins
        start_run(2, 1, 1'b1, n0);
        idle(4);
        check_strobes("t8", n0, 2, 1, 2);
        chk("t8_idx_a", int'(bus_a.idx_out), 8);
        chk("t8_idx_b", int'(bus_b.idx_out), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/evt_burst_gen.md
Name: evt_burst_gen

Overview:
- Transmit-side counterpart to the event counter: generates single-cycle evt strobes at a programmed period, either for a programmed number of events or continuously.
- Carries an event index that wraps at MAX_COUNT exactly as the downstream counter does, so a counter fed by evt_out matches idx_out after every strobe.
- Drives test stimulus and paced triggers (sample strobes, frame ticks) inside the fabric.

Parameters:
- MAX_COUNT, 40_000, wrap modulus of idx_out; must satisfy 2 <= MAX_COUNT <= 65536.
- CNT_W, 16, width of period, burst length and index.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- start_in  input  1  start request; sampled only in IDLE.
- stop_in  input  1  abort request; honoured in RUN.
- period_in  input  CNT_W  clock cycles between strobes; latched at start.
- burst_in  input  CNT_W  number of strobes; 0 = continuous; latched at start.
- evt_out  output  1  single-cycle event strobe.
- idx_out  output  CNT_W  count of strobes emitted, mod MAX_COUNT.
- busy_out  output  1  high while in RUN.
- done_out  output  1  single-cycle pulse on burst completion or stop.

Behaviour:
- Reset is asynchronous and active-high on rst_in; clocked on clk_in. On assertion: state=IDLE, evt_out=0, idx_out=0, busy_out=0, done_out=0, internal timers=0. The same values apply when reset is asserted mid-burst; no done_out is emitted.
- States are IDLE and RUN.
- IDLE:
  - start_in=1 at edge N latches period_in and burst_in, clears the period timer and the remaining counter, and enters RUN.
  - busy_out=1 from N+1.
  - idx_out is NOT cleared by start; it continues from its previous value, mirroring a free-running receiver.
- Period rule: effective period P = max(period_in, 1).
  - The first evt_out is high in cycle N+P, meaning visible after edge N+P.
  - Subsequent strobes occur every P cycles.
  - When P=1, evt_out is high every cycle while in RUN.
- Strobe:
  - In the cycle evt_out=1, idx_out updates on the same edge that raises evt_out, so the index reads post-increment.
  - idx_out = (idx_out == MAX_COUNT-1) ? 0 : idx_out+1.
- Burst end (burst_in=B>0):
  - On the edge that emits strobe B: evt_out=1 and done_out=1 in the same cycle; state returns to IDLE, and busy_out=0 in that cycle.
  - Exactly B strobes are emitted.
- Continuous (B=0): runs until stop_in.
- stop_in in RUN:
  - Next edge enters IDLE with done_out=1 and busy_out=0.
  - If a strobe would fall on that same edge, stop wins: no strobe is emitted and idx_out is unchanged.
- stop_in in IDLE is ignored.
- start_in in RUN is ignored.
- start_in and stop_in together in IDLE: start is taken.
- Inputs period_in and burst_in may change freely during RUN; only the values latched at start are used.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Shared package evt_pkg holds:
  - typedef enum logic {IDLE, RUN} evt_gen_state_t;
  - localparam CNT_W_DEFAULT = 16;
  - the index wrap function next_idx(cur, max).
- The existing event counter adopts next_idx as well.
- One sub-module, evt_period_timer:
  - Down-counter loaded with P-1 on load; emits a tick when it reaches 0 and enabled, then reloads.
  - evt_burst_gen contains the FSM, burst counter and index register.

Test Plan:
1. Reset, then start with period=4, burst=3 -> evt_out high at cycles N+4, N+8, N+12; idx_out 1,2,3; done_out high at N+12; busy_out low after.
2. period=0, burst=5 -> five consecutive evt_out cycles N+1..N+5; idx_out ends at 5; done_out coincides with the fifth strobe.
3. MAX_COUNT=5, preset idx_out=3 via prior burst of 3, then burst=4 period=1 -> idx_out sequence 4,0,1,2; an evt_counter instance on evt_out reads identical values.
4. Continuous mode, period=10, stop_in asserted on the cycle before the 3rd strobe -> only 2 strobes; done_out one cycle; idx_out=2.
5. Reset asserted asynchronously mid-burst (between clock edges) -> all outputs 0 immediately; no done_out; subsequent start runs normally from idx 0.
6. start_in pulsed again during RUN, and period_in/burst_in changed mid-run -> ignored; strobe timing and count unchanged from the latched values.
